// File: rtl/garuda_drain_pkg.sv
// Shared types and constants for the accumulator drain / requantization path.
package garuda_drain_pkg;

    localparam int ACC_W   = 32;
    localparam int SCALE_W = 16;
    localparam int OUT_W   = 8;
    localparam int SHIFT_W = 5;

    // Signed product of one accumulator and the scale multiplier.
    localparam int PROD_W  = ACC_W + SCALE_W;

    // Saturation bounds of the signed output element.
    localparam int SAT_MAX = (1 << (OUT_W - 1)) - 1;
    localparam int SAT_MIN = -(1 << (OUT_W - 1));

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } drain_state_e;

    typedef struct packed {
        logic signed [SCALE_W-1:0] scale;
        logic        [SHIFT_W-1:0] shift;
        logic signed [OUT_W-1:0]   zero_point;
        logic                      relu_en;
    } requant_cfg_t;

endpackage

// File: rtl/requant_lane.sv
// One lane of the requant pipe: S2 multiplies, S3 rounds/shifts/offsets/saturates.
module requant_lane
    import garuda_drain_pkg::*;
#(
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        en_s2_i,
    input  logic                        en_s3_i,
    input  logic signed [ACC_WIDTH-1:0] acc_i,
    input  requant_cfg_t                cfg_i,
    output logic signed [OUT_WIDTH-1:0] q_o
);

    localparam int PW = ACC_WIDTH + SCALE_W;

    logic signed [PW-1:0]    prod_q;
    logic signed [PW:0]      rnd;
    logic signed [PW:0]      rounded;
    logic signed [PW:0]      shifted;
    logic signed [PW+1:0]    offs;
    logic signed [OUT_WIDTH-1:0] sat;

    // S3 combinational path: round-half-up, arithmetic shift, ReLU, offset, clamp.
    always_comb begin
        rnd = '0;
        if (cfg_i.shift != '0)
            rnd = {{PW{1'b0}}, 1'b1} << (cfg_i.shift - 5'd1);
        // One guard bit keeps the rounding add from overflowing the product range.
        rounded = (PW+1)'(prod_q) + rnd;
        shifted = rounded >>> cfg_i.shift;
        // ReLU acts before the zero point is applied.
        if (cfg_i.relu_en && shifted < 0)
            shifted = '0;
        offs = (PW+2)'(shifted) + (PW+2)'(cfg_i.zero_point);
        if (offs > SAT_MAX)
            sat = OUT_WIDTH'(SAT_MAX);
        else if (offs < SAT_MIN)
            sat = OUT_WIDTH'(SAT_MIN);
        else
            sat = offs[OUT_WIDTH-1:0];
    end

    // S2 product register and S3 output register, each advanced by its own enable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prod_q <= '0;
            q_o    <= '0;
        end else begin
            if (en_s2_i) prod_q <= acc_i * cfg_i.scale;
            if (en_s3_i) q_o    <= sat;
        end
    end

endmodule

// File: rtl/accumulator_drain.sv
// Drains a region of the accumulator buffer, requantizes each lane to int8,
// and streams packed beats out over valid/ready.
module accumulator_drain
    import garuda_drain_pkg::*;
#(
    parameter int DEPTH       = 8192,
    parameter int ADDR_WIDTH  = 13,
    parameter int NUM_LANES   = 16,
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_WIDTH   = 8,
    parameter int SCALE_WIDTH = 16,
    parameter int BEAT_WIDTH  = 10
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            start_i,
    input  logic [ADDR_WIDTH-1:0]           base_addr_i,
    input  logic [BEAT_WIDTH-1:0]           num_beats_i,
    input  logic [SCALE_WIDTH-1:0]          scale_i,
    input  logic [4:0]                      shift_i,
    input  logic [OUT_WIDTH-1:0]            zero_point_i,
    input  logic                            relu_en_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            error_o,
    output logic                            acc_rd_en_o,
    output logic [ADDR_WIDTH-1:0]           acc_rd_addr_o,
    input  logic [NUM_LANES*ACC_WIDTH-1:0]  acc_rd_data_i,
    input  logic                            acc_rd_valid_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [NUM_LANES*OUT_WIDTH-1:0]  out_data_o,
    output logic                            out_last_o
);

    localparam int STAGES = 3;

    drain_state_e                          state;
    requant_cfg_t                          cfg_q;
    logic [ADDR_WIDTH-1:0]                 rd_addr_q;
    logic [BEAT_WIDTH-1:0]                 rd_cnt_q;
    logic [BEAT_WIDTH-1:0]                 num_beats_q;
    logic [STAGES:1]                       vld_pipe;
    logic [STAGES:1]                       last_pipe;
    logic [NUM_LANES-1:0][ACC_WIDTH-1:0]   s1_acc;
    logic [NUM_LANES-1:0][OUT_WIDTH-1:0]   s3_q;
    logic                                  stall, adv, rd_fire, rd_last, out_fire;
    logic [31:0]                           end_addr;

    // A stalled output freezes the whole pipe and suppresses new reads.
    assign stall       = vld_pipe[STAGES] && !out_ready_i;
    assign adv         = !stall;
    assign acc_rd_en_o = (state == RUN) && !stall;
    assign acc_rd_addr_o = rd_addr_q;
    // Read valid low is a retry: address and beat count hold.
    assign rd_fire     = acc_rd_en_o && acc_rd_valid_i;
    assign rd_last     = (rd_cnt_q == num_beats_q - BEAT_WIDTH'(1));
    assign out_fire    = out_valid_o && out_ready_i;

    // Region end at full width so a region running past the buffer cannot wrap.
    assign end_addr = 32'(base_addr_i) + 32'(num_beats_i) * 32'(NUM_LANES);

    // Control FSM: launch/range check, address walk, completion.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            cfg_q       <= '0;
            rd_addr_q   <= '0;
            rd_cnt_q    <= '0;
            num_beats_q <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            error_o     <= 1'b0;
        end else begin
            done_o  <= 1'b0;
            error_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        cfg_q       <= '{scale: scale_i, shift: shift_i,
                                         zero_point: zero_point_i, relu_en: relu_en_i};
                        rd_addr_q   <= base_addr_i;
                        rd_cnt_q    <= '0;
                        num_beats_q <= num_beats_i;
                        if (num_beats_i == '0) begin
                            done_o <= 1'b1;
                        end else if (end_addr > 32'(DEPTH)) begin
                            error_o <= 1'b1;
                        end else begin
                            state  <= RUN;
                            busy_o <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (rd_fire) begin
                        rd_addr_q <= rd_addr_q + ADDR_WIDTH'(NUM_LANES);
                        rd_cnt_q  <= rd_cnt_q + BEAT_WIDTH'(1);
                        if (rd_last) state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (out_fire && out_last_o) begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // S1 capture plus the valid/last shift registers that shadow S1..S3.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            s1_acc    <= '0;
        end else if (adv) begin
            vld_pipe  <= {vld_pipe[STAGES-1:1], rd_fire};
            last_pipe <= {last_pipe[STAGES-1:1], rd_fire && rd_last};
            if (rd_fire) s1_acc <= acc_rd_data_i;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        requant_lane #(
            .ACC_WIDTH (ACC_WIDTH),
            .OUT_WIDTH (OUT_WIDTH)
        ) u_lane (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .en_s2_i (adv && vld_pipe[1]),
            .en_s3_i (adv && vld_pipe[2]),
            .acc_i   (s1_acc[i]),
            .cfg_i   (cfg_q),
            .q_o     (s3_q[i])
        );
    end

    assign out_data_o  = s3_q;
    assign out_valid_o = vld_pipe[STAGES];
    assign out_last_o  = last_pipe[STAGES];

endmodule

// File: tb/tb_accumulator_drain.sv
// Self-checking bench for accumulator_drain: table vectors, directed corner
// sequences, and randomized drains against a plain-arithmetic model.
module tb_accumulator_drain;

    localparam int DEPTH = 8192;
    localparam int AW    = 13;
    localparam int NL    = 16;
    localparam int BW    = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start;
    logic [AW-1:0] base;
    logic [BW-1:0] nbeats;
    logic [15:0]   scale;
    logic [4:0]    shift;
    logic [7:0]    zp;
    logic          relu;
    logic          busy, done, err, rd_en, rd_valid, ov, ordy, olast;
    logic [AW-1:0] rd_addr;
    logic [NL*32-1:0] rd_data;
    logic [NL*8-1:0]  od;

    int mem [DEPTH];
    int checks = 0;
    int errors = 0;
    logic [127:0] last_od;

    accumulator_drain dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .base_addr_i(base),
        .num_beats_i(nbeats), .scale_i(scale), .shift_i(shift),
        .zero_point_i(zp), .relu_en_i(relu), .busy_o(busy), .done_o(done),
        .error_o(err), .acc_rd_en_o(rd_en), .acc_rd_addr_o(rd_addr),
        .acc_rd_data_i(rd_data), .acc_rd_valid_i(rd_valid),
        .out_valid_o(ov), .out_ready_i(ordy), .out_data_o(od),
        .out_last_o(olast)
    );

    // Buffer model: a wide read returns NL consecutive words in the same cycle.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NL; i++)
            if (int'(rd_addr) + i < DEPTH)
                rd_data[i*32 +: 32] = mem[int'(rd_addr) + i];
    end

    function automatic logic [7:0] ref_q(int acc, int sc, int sh, int z, bit rl);
        longint p;
        p = longint'(acc) * longint'(sc);
        if (sh > 0) p = p + (longint'(1) << (sh - 1));
        p = p >>> sh;
        if (rl && p < 0) p = 0;
        p = p + z;
        if (p > 127) p = 127;
        else if (p < -128) p = -128;
        return p[7:0];
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // kind: 0 normal drain, 1 zero beats, 2 range error.
    // rmode: 0 ready high, 1 ready 1,0,0 repeating, 2 random.  vmode: 0 read valid high, 1 random.
    // rst_at > 0: assert reset while beat rst_at+1 is presented.
    task automatic run_drain(input int b, input int nb, input int sc, input int sh,
                             input int z, input bit rl, input int rmode, input int vmode,
                             input int kind, input int rst_at);
        logic [127:0] exp_q[$];
        int exp_addr[$];
        int nhs = 0, nrd = 0, nrd_en = 0, ndone = 0, nerr = 0, nov = 0, nbusy = 0;
        int first_rd = -1, first_ov = -1, hs_last = -1, done_cyc = -1, err_cyc = -1;
        logic busy_c1 = 1'b0;
        logic [127:0] prev_d = '0;
        logic prev_l = 1'b0, prev_stall = 1'b0;
        if (kind == 0) begin
            for (int bb = 0; bb < nb; bb++) begin
                logic [127:0] v;
                for (int l = 0; l < NL; l++)
                    v[l*8 +: 8] = ref_q(mem[b + bb*NL + l], sc, sh, z, rl);
                exp_q.push_back(v);
                exp_addr.push_back(b + bb*NL);
            end
        end
        @(negedge clk);
        start = 1'b1; base = AW'(b); nbeats = BW'(nb); scale = sc[15:0];
        shift = sh[4:0]; zp = z[7:0]; relu = rl; ordy = 1'b1; rd_valid = 1'b1;
        @(negedge clk);
        // Scramble the config bus: the drain must use its latched copy.
        start = 1'b0; base = AW'($urandom); nbeats = BW'($urandom); scale = 16'($urandom);
        shift = 5'($urandom); zp = 8'($urandom); relu = 1'($urandom);
        for (int cyc = 1; cyc <= 600; cyc++) begin
            case (rmode)
                0: ordy = 1'b1;
                1: ordy = ((cyc - 1) % 3 == 0);
                default: ordy = 1'($urandom_range(0, 1));
            endcase
            rd_valid = (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            if (prev_stall) begin
                chk("hold_valid", ov, 1'b1);
                chk("hold_data", od, prev_d);
                chk("hold_last", olast, prev_l);
            end
            prev_stall = ov && !ordy; prev_d = od; prev_l = olast;
            if (cyc == 1) busy_c1 = busy;
            if (busy) nbusy++;
            if (rst_at > 0 && nhs == rst_at && ov) begin
                rst_n = 1'b0;
                #1;
                chk("midreset_ctrl", {busy, done, err, rd_en, ov, olast}, '0);
                chk("midreset_data", od, '0);
                chk("midreset_addr", rd_addr, '0);
                chk("midreset_no_done", ndone, 0);
                @(negedge clk);
                rst_n = 1'b1;
                ordy = 1'b1;
                return;
            end
            if (rd_en) begin
                nrd_en++;
                if (first_rd < 0) first_rd = cyc;
                if (rd_valid) begin
                    if (nrd < exp_addr.size()) chk("rd_addr", rd_addr, exp_addr[nrd]);
                    else chk("extra_read", nrd, exp_addr.size());
                    nrd++;
                end
            end
            if (ov) begin
                nov++;
                if (first_ov < 0) first_ov = cyc;
            end
            if (ov && ordy) begin
                if (nhs < exp_q.size()) begin
                    chk("beat_data", od, exp_q[nhs]);
                    chk("beat_last", olast, (nhs == nb - 1));
                end else begin
                    chk("extra_beat", nhs, exp_q.size());
                end
                last_od = od;
                nhs++;
                if (olast) hs_last = cyc;
            end
            if (done) begin
                ndone++; done_cyc = cyc;
                chk("busy_at_done", busy, 1'b0);
            end
            if (err) begin nerr++; err_cyc = cyc; end
            if (kind == 0 && done_cyc > 0 && cyc >= done_cyc + 2) break;
            if (kind != 0 && cyc >= 8) break;
            @(negedge clk);
        end
        if (kind == 0) begin
            chk("beat_count", nhs, nb);
            chk("read_count", nrd, nb);
            chk("done_count", ndone, 1);
            chk("done_timing", done_cyc, hs_last + 1);
            chk("no_error", nerr, 0);
            chk("busy_after_start", busy_c1, 1'b1);
            chk("first_read_cycle", first_rd, 1);
            if (vmode == 0) chk("first_valid_cycle", first_ov, 4);
            if (vmode == 0 && rmode == 0) chk("throughput", hs_last, nb + 3);
        end else if (kind == 1) begin
            chk("zero_done", ndone, 1);
            chk("zero_done_cycle", done_cyc, 1);
            chk("zero_no_valid", nov, 0);
            chk("zero_no_read", nrd_en, 0);
            chk("zero_no_busy", nbusy, 0);
        end else begin
            chk("err_count", nerr, 1);
            chk("err_cycle", err_cyc, 1);
            chk("err_no_read", nrd_en, 0);
            chk("err_no_done", ndone, 0);
            chk("err_no_busy", nbusy, 0);
        end
    endtask

    typedef struct {
        int          acc;
        int          sc;
        int          sh;
        int          z;
        bit          rl;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        start = 1'b0; base = '0; nbeats = '0; scale = '0; shift = '0; zp = '0;
        relu = 1'b0; ordy = 1'b1; rd_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++)
            mem[i] = (i % 3 == 0) ? int'($urandom) : int'($urandom_range(0, 4000)) - 2000;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ctrl", {busy, done, err, rd_en, ov, olast}, '0);
        chk("reset_data", od, '0);
        chk("reset_addr", rd_addr, '0);
        rst_n = 1'b1;

        // Lane-0 vectors with hand-computed results.
        vecs.push_back('{1000,    1,  3, 0,  1'b0, 8'd125});
        vecs.push_back('{-1000,   1,  3, 0,  1'b0, 8'h83});   // -125
        vecs.push_back('{100000,  1,  0, 0,  1'b0, 8'h7f});   // 127
        vecs.push_back('{-100000, 1,  0, 0,  1'b0, 8'h80});   // -128
        vecs.push_back('{300,    -2,  1, 0,  1'b0, 8'h80});   // -128
        vecs.push_back('{-5,      1,  0, 10, 1'b1, 8'd10});
        vecs.push_back('{-5,      1,  0, 10, 1'b0, 8'd5});
        vecs.push_back('{7,       1,  1, 0,  1'b0, 8'd4});
        vecs.push_back('{-7,      1,  1, 0,  1'b0, 8'hfd});   // -3
        vecs.push_back('{1,       3,  0, -128, 1'b0, 8'h83}); // -125
        foreach (vecs[k]) begin
            mem[0] = vecs[k].acc;
            mem[1] = -vecs[k].acc;
            run_drain(0, 1, vecs[k].sc, vecs[k].sh, vecs[k].z, vecs[k].rl, 0, 0, 0, 0);
            chk($sformatf("vec%0d_lane0", k), last_od[7:0], vecs[k].exp);
        end

        // Four beats from 64 under a 1,0,0 ready pattern.
        run_drain(64, 4, 3, 2, -3, 1'b0, 1, 0, 0, 0);
        // Region ending exactly at the top of the buffer is legal.
        run_drain(DEPTH - NL, 1, 1, 4, 0, 1'b1, 0, 0, 0, 0);
        // Out-of-range region and empty drain.
        run_drain(8190, 1, 1, 0, 0, 1'b0, 0, 0, 2, 0);
        run_drain(0, 0, 1, 0, 0, 1'b0, 0, 0, 1, 0);
        // Reset while beat 2 of 4 is presented, then a fresh drain.
        run_drain(128, 4, 1, 0, 0, 1'b0, 0, 0, 0, 1);
        run_drain(256, 4, 2, 3, 5, 1'b0, 0, 0, 0, 0);

        // Randomized drains with random backpressure and read retries.
        for (int r = 0; r < 8; r++) begin
            int nb, b;
            nb = $urandom_range(1, 8);
            b  = $urandom_range(0, DEPTH - nb*NL);
            run_drain(b, nb, int'($urandom_range(0, 600)) - 300, $urandom_range(0, 31),
                      int'($urandom_range(0, 255)) - 128, 1'($urandom_range(0, 1)),
                      (r % 2 == 0) ? 2 : 1, 1, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
